// File: rtl/serial_addsub5.sv
// serial_addsub5: bit-serial LSB-first adder/subtractor around one registered full-adder slice,
// with valid/ready handshakes on operands and results.
module serial_addsub5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, acc_q, acc_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic s, cout;
  assign s    = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign cout = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? SHIFT : IDLE;
      SHIFT:   state_d = (cnt_q == LAST) ? DONE : SHIFT;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // Subtraction inverts b at load and seeds the carry with 1, so the slice only ever adds.
  always_comb begin
    sa_d        = sa_q;
    sb_d        = sb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    if (state_q == IDLE && in_valid) begin
      sa_d    = a;
      sb_d    = b ^ {WIDTH{op}};
      carry_d = op;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      sa_d    = sa_q >> 1;
      sb_d    = sb_q >> 1;
      acc_d   = {s, acc_q[WIDTH-1:1]};
      carry_d = cout;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        result_d    = {s, acc_q[WIDTH-1:1]};
        carry_out_d = cout;
        overflow_d  = carry_q ^ cout;
      end
    end
  end
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end
endmodule

// File: tb/tb_serial_addsub5.sv
// tb_serial_addsub5: directed and streamed checks of the serial adder/subtractor.
module tb_serial_addsub5;
  localparam int WIDTH = 5;
  logic clk, rst_n, in_valid, in_ready, op, out_valid, out_ready, carry_out, overflow;
  logic [WIDTH-1:0] a, b, result;
  logic o;
  logic [WIDTH-1:0] x, y;
  logic [6:0] exp7;
  int checks, errors, n;
  serial_addsub5 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] model(input logic mo, input logic [4:0] mx, input logic [4:0] my);
    int sx, sy, t;
    logic [4:0] r;
    logic c, v;
    sx = int'($signed(mx));
    sy = int'($signed(my));
    t  = mo ? sx - sy : sx + sy;
    r  = mo ? mx - my : mx + my;
    c  = mo ? (mx >= my) : (({1'b0, mx} + {1'b0, my}) > 6'd31);
    v  = (t > 15) || (t < -16);
    return {r, c, v};
  endfunction
  task automatic do_op(input string tag, input logic to, input logic [4:0] tx, input logic [4:0] ty,
                       input logic [4:0] er, input logic ec, input logic ev);
    int k;
    chk({tag, "_idle"}, in_ready, 1);
    op = to; a = tx; b = ty; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~tx; b = ~ty; op = ~to;
    chk({tag, "_busy"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk({tag, "_lat"}, k, 5);
    chk({tag, "_res"}, result, er);
    chk({tag, "_co"}, carry_out, ec);
    chk({tag, "_ov"}, overflow, ev);
    @(posedge clk); #1;
    chk({tag, "_after"}, {in_ready, out_valid}, 2'b10);
  endtask
  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {in_ready, out_valid, result, carry_out, overflow}, {2'b10, 5'b00000, 2'b00});
    rst_n = 1'b1;
    do_op("add_3_4", 1'b0, 5'b00011, 5'b00100, 5'b00111, 1'b0, 1'b0);
    do_op("sub_5_1", 1'b1, 5'b00101, 5'b00001, 5'b00100, 1'b1, 1'b0);
    do_op("sub_0_1", 1'b1, 5'b00000, 5'b00001, 5'b11111, 1'b0, 1'b0);
    do_op("add_ovf", 1'b0, 5'b01111, 5'b00001, 5'b10000, 1'b0, 1'b1);
    do_op("add_wrap", 1'b0, 5'b11111, 5'b00001, 5'b00000, 1'b1, 1'b0);
    do_op("sub_ovf", 1'b1, 5'b10000, 5'b00001, 5'b01111, 1'b1, 1'b1);
    op = 1'b0; a = 5'b00011; b = 5'b00011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_hold", {out_valid, result, carry_out, overflow}, {1'b0, 5'b01111, 2'b11});
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_rst", {in_ready, out_valid, result, carry_out, overflow}, {2'b10, 5'b00000, 2'b00});
    do_op("abort_next", 1'b0, 5'b00001, 5'b00001, 5'b00010, 1'b0, 1'b0);
    op = 1'b0; a = 5'b00011; b = 5'b00100; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_lat", n, 5);
    a = 5'b00001; b = 5'b00001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, result, carry_out, overflow}, {2'b10, 5'b00111, 2'b00});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {in_ready, out_valid, result}, {2'b10, 5'b00111});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_res", {n[4:0], result, carry_out, overflow}, {5'd5, 5'b00010, 2'b00});
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      o = 1'($urandom); x = 5'($urandom); y = 5'($urandom);
      exp7 = model(o, x, y);
      op = o; a = x; b = y;
      @(posedge clk); #1;
      a = ~x; b = ~y; op = ~o;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bb_res", {result, carry_out, overflow}, exp7);
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("bb_period", n + 1, WIDTH + 2);
    end
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_addsub5.md
Name: serial_addsub5

Overview:
- Bit-serial 5-bit adder/subtractor, LSB first, built around a single registered full-adder slice.
- Sits directly downstream of the 5-bit two's-complement negator stage and consumes the same operand format.
- Subtraction is formed in the serial datapath as a + (~b) + 1, i.e. the two's complement is applied on the fly.
- Operands arrive through a valid/ready handshake; results leave through a valid/ready handshake with carry and signed-overflow flags.

Parameters:
- WIDTH, 5, operand/result width in bits; also the number of serial cycles per operation.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operand set present on a, b, op.
- in_ready  output  1  block can accept an operand set.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  operand A (two's complement or unsigned).
- b  input  WIDTH  operand B.
- out_valid  output  1  result, carry_out and overflow are valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  sum/difference modulo 2^WIDTH.
- carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, bit counter=0, internal shift registers=0. Reset has priority over every other event.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On in_valid & in_ready at an edge: latch a into shift reg SA.
  - Latch b XOR {WIDTH{op}} into shift reg SB.
  - Set carry reg = op; set counter = 0; go to SHIFT.
  - op, a and b are sampled only at this edge.
- SHIFT, each edge:
  - s = SA[0] ^ SB[0] ^ carry, and carry <= majority(SA[0], SB[0], carry).
  - s shifts into the MSB of an accumulator register (right shift); SA and SB shift right; counter++.
  - On the edge where counter == WIDTH-1:
    - capture the carry-in of that bit as cin_msb;
    - load result <= final accumulator value;
    - load carry_out <= carry-out of that bit;
    - load overflow <= cin_msb ^ carry-out;
    - go to DONE.
- Latency: accepted at edge E0, SHIFT edges E1..E_WIDTH. out_valid is high in the cycle after E_WIDTH, so the result is available WIDTH cycles after acceptance.
- DONE:
  - result, carry_out and overflow stay stable while out_valid=1 & out_ready=0, for any number of cycles.
  - On out_valid & out_ready: go to IDLE, so in_ready=1 the next cycle.
  - result, carry_out and overflow hold their last values in IDLE and SHIFT. They change only on entry to DONE or on reset.
- No overlap: in_valid while state != IDLE is ignored and the operand is not consumed; upstream must hold it.
- Arithmetic wraps modulo 2^WIDTH. The result register never changes width and carry is never folded into result.
- Reset mid-SHIFT or mid-DONE: the operation is aborted with no partial result; all outputs take their reset values the next cycle.
- out_ready asserted outside DONE has no effect.

Test Plan:
- Add 00011+00100, out_ready=1: in_ready drops the cycle after acceptance; out_valid high exactly 5 cycles after the accept edge with result=00111, carry_out=0, overflow=0; in_ready=1 the next cycle.
- Subtract 00101-00001 -> result=00100, carry_out=1, overflow=0. Subtract 00000-00001 -> result=11111, carry_out=0, overflow=0.
- Overflow:
  - Add 01111+00001 -> result=10000, carry_out=0, overflow=1.
  - Subtract 10000-00001 -> result=01111, carry_out=1, overflow=1.
  - Add 11111+00001 -> result=00000, carry_out=1, overflow=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE: out_valid stays 1, result/flags stay constant, in_ready stays 0.
  - A new in_valid with a=00001, b=00001 is not accepted.
  - With out_ready=1: handshake, IDLE, then that operand is accepted and yields 00010.
- Reset abort: assert rst_n=0 for one edge during the 3rd SHIFT cycle. Next cycle: in_ready=1, out_valid=0, result=00000, carry_out=0, overflow=0, and a following add 00001+00001 completes normally with 00010.
- Back-to-back: stream 5 operand sets with in_valid and out_ready held high. Each completes in WIDTH+2 cycles from accept to next accept, with results matching a reference model over a random sweep of all op/a/b combinations.
